// File: rtl/pkg_system_mdr.sv
// Shared types and constants for the MDR (multiply/divide/root) unit.
package pkg_system_mdr;

  localparam int unsigned DW  = 16;  // radicand width
  localparam int unsigned DW2 = 32;  // result/remainder width
  localparam int unsigned CW  = 8;   // iteration counter width

  // Two radicand bits are consumed per iteration.
  localparam int unsigned ROOT_ITER = DW / 2;

  typedef logic [DW-1:0]  data_in_t;
  typedef logic [DW2-1:0] data_t;
  typedef logic [CW-1:0]  count8_t;

  typedef enum logic [2:0] {
    RS_IDLE,
    RS_LOAD,
    RS_RUN,
    RS_CAPTURE,
    RS_DONE
  } root_seq_state_e;

endpackage

// File: rtl/root_iter_counter.sv
// Iteration index for the square-root sequencer: synchronous clear, count enable,
// saturation at Iter-1 with a terminal-count flag.
module root_iter_counter
  import pkg_system_mdr::*;
#(
  parameter int unsigned Iter = ROOT_ITER
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    clr_i,
  input  logic    en_i,
  output count8_t cnt_o,
  output logic    tc_o
);

  localparam count8_t TcVal = count8_t'(Iter - 1);

  count8_t cnt_q, cnt_d;

  assign tc_o  = (cnt_q == TcVal);
  assign cnt_o = cnt_q;

  // Next count: clear wins, otherwise step until the terminal value and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + count8_t'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/root_sequencer.sv
// Control stage in front of the square-root datapath: accepts a radicand, drives the
// datapath through ROOT_ITER iterations, captures root/remainder and pulses o_done.
module root_sequencer
  import pkg_system_mdr::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_start,
  input  logic     i_abort,
  input  data_in_t i_val_x,
  input  data_t    i_dp_result,
  input  data_t    i_dp_reminder,
  output logic     o_ready,
  output logic     o_busy,
  output logic     o_init,
  output logic     o_enable,
  output count8_t  o_counter,
  output data_in_t o_val_x,
  output logic     o_done,
  output data_t    o_result,
  output data_t    o_reminder
);

  root_seq_state_e state_q, state_d;

  logic     ready_q, init_q, enable_q, done_q;
  data_in_t val_x_q;
  data_t    result_q, reminder_q;

  count8_t  cnt;
  logic     cnt_tc, cnt_clr, cnt_en;
  logic     accept, capture;

  // Count only in RUN; leaving RUN (terminal count or abort) returns the index to 0,
  // so the counter already reads 0 in LOAD and in every non-RUN state.
  assign cnt_en  = (state_q == RS_RUN);
  assign cnt_clr = (state_q != RS_RUN) | i_abort | cnt_tc;

  root_iter_counter #(
    .Iter (ROOT_ITER)
  ) u_iter_counter (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt),
    .tc_o   (cnt_tc)
  );

  // Next-state logic; abort overrides every transition out of a busy state.
  always_comb begin
    state_d = state_q;
    if (i_abort && (state_q != RS_IDLE)) begin
      state_d = RS_IDLE;
    end else begin
      unique case (state_q)
        RS_IDLE:    if (i_start && !i_abort) state_d = RS_LOAD;
        RS_LOAD:    state_d = RS_RUN;
        RS_RUN:     if (cnt_tc) state_d = RS_CAPTURE;
        RS_CAPTURE: state_d = RS_DONE;
        RS_DONE:    state_d = RS_IDLE;
        default:    state_d = RS_IDLE;
      endcase
    end
  end

  assign accept  = (state_q == RS_IDLE) && (state_d == RS_LOAD);
  assign capture = (state_q == RS_CAPTURE) && (state_d == RS_DONE);

  // State, registered strobes (decoded from the next state) and data capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RS_IDLE;
      ready_q    <= 1'b1;
      init_q     <= 1'b0;
      enable_q   <= 1'b0;
      done_q     <= 1'b0;
      val_x_q    <= '0;
      result_q   <= '0;
      reminder_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d == RS_IDLE);
      init_q   <= (state_d == RS_LOAD);
      enable_q <= (state_d == RS_RUN);
      done_q   <= (state_d == RS_DONE);
      if (accept) begin
        val_x_q <= i_val_x;
      end
      // Datapath output register has settled during CAPTURE; pass values through as-is.
      if (capture) begin
        result_q   <= i_dp_result;
        reminder_q <= i_dp_reminder;
      end
    end
  end

  assign o_ready    = ready_q;
  assign o_busy     = ~ready_q;
  assign o_init     = init_q;
  assign o_enable   = enable_q;
  assign o_counter  = cnt;
  assign o_val_x    = val_x_q;
  assign o_done     = done_q;
  assign o_result   = result_q;
  assign o_reminder = reminder_q;

`ifndef SYNTHESIS
  // Init and iterate strobes never overlap; done is always a single-cycle pulse.
  a_init_enable_excl: assert property (@(posedge clk) disable iff (!rst) !(o_init && o_enable));
  a_done_pulse:       assert property (@(posedge clk) disable iff (!rst) o_done |=> !o_done);
`endif

endmodule

// File: tb/tb_root_sequencer.sv
// Scoreboard bench for root_sequencer with a behavioural digit-by-digit square-root
// datapath attached; expectations come from a plain integer square root.
module tb_root_sequencer;
  import pkg_system_mdr::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     i_start, i_abort;
  data_in_t i_val_x;
  data_t    i_dp_result, i_dp_reminder;
  logic     o_ready, o_busy, o_init, o_enable, o_done;
  count8_t  o_counter;
  data_in_t o_val_x;
  data_t    o_result, o_reminder;

  always #5 clk = ~clk;

  root_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_val_x       (i_val_x),
    .i_dp_result   (i_dp_result),
    .i_dp_reminder (i_dp_reminder),
    .o_ready       (o_ready),
    .o_busy        (o_busy),
    .o_init        (o_init),
    .o_enable      (o_enable),
    .o_counter     (o_counter),
    .o_val_x       (o_val_x),
    .o_done        (o_done),
    .o_result      (o_result),
    .o_reminder    (o_reminder)
  );

  // ---------------- behavioural datapath stand-in ----------------
  logic [15:0] dp_x    = '0;
  logic [31:0] dp_root = '0;
  logic [31:0] dp_rem  = '0;

  function automatic logic [63:0] dp_step(logic [15:0] x, logic [31:0] root,
                                          logic [31:0] rem, logic [7:0] k);
    logic [31:0] pair, r2, t;
    pair = 32'd0;
    if (k < 8'd8) pair = 32'((x >> (14 - 2 * int'(k))) & 16'h3);
    r2 = (rem << 2) | pair;
    t  = (root << 2) | 32'd1;
    if (r2 >= t) return {(root << 1) | 32'd1, r2 - t};
    return {root << 1, r2};
  endfunction

  always @(posedge clk) begin
    if (o_init) begin
      dp_x    <= o_val_x;
      dp_root <= '0;
      dp_rem  <= '0;
    end else if (o_enable) begin
      {dp_root, dp_rem} <= dp_step(dp_x, dp_root, dp_rem, o_counter);
    end
  end

  assign i_dp_result   = dp_root;
  assign i_dp_reminder = dp_rem;

  // ---------------- reference model and scoreboard ----------------
  function automatic int isqrt(int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  typedef struct {
    int          due;
    logic [31:0] res;
    logic [31:0] rem;
  } exp_t;

  exp_t        sb[$];
  int          cyc    = 0;
  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          m_busy = 1'b0;
  int          m_acc  = 0;
  int          m_p, m_r;
  logic [15:0] m_val  = '0;
  logic [31:0] m_res  = '0;
  logic [31:0] m_rem  = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Asynchronous reset discards any operation in flight and clears the captured values.
  always @(negedge rst) begin
    m_busy = 1'b0;
    m_val  = '0;
    m_res  = '0;
    m_rem  = '0;
    sb.delete();
  end

  // An operation accepted at edge A: LOAD after A, RUN after A+1..A+8, CAPTURE after A+9,
  // DONE after A+10, back to IDLE after A+11; next start can be sampled at A+12.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      if (m_busy) begin
        m_p = cyc - 1 - m_acc;
        if (i_abort) begin
          m_busy = 1'b0;
          sb.delete();
        end else if (m_p >= 10) begin
          m_busy = 1'b0;
        end else if (m_p == 9) begin
          m_r   = isqrt(int'(m_val));
          m_res = 32'(m_r);
          m_rem = 32'(int'(m_val) - m_r * m_r);
        end
      end else if (i_start && !i_abort) begin
        m_busy = 1'b1;
        m_acc  = cyc;
        m_val  = i_val_x;
        m_r    = isqrt(int'(i_val_x));
        sb.push_back('{cyc + 10, 32'(m_r), 32'(int'(i_val_x) - m_r * m_r)});
      end
    end
  end

  // Monitor: per-cycle control outputs against the model, done pulses against the queue.
  always @(negedge clk) begin
    int   ph;
    logic e_init, e_en, e_done;
    exp_t e;
    ph     = cyc - m_acc;
    e_init = m_busy && (ph == 0);
    e_en   = m_busy && (ph >= 1) && (ph <= 8);
    e_done = m_busy && (ph == 10);
    chk("ready",    32'(o_ready),   32'(!m_busy));
    chk("busy",     32'(o_busy),    32'(m_busy));
    chk("init",     32'(o_init),    32'(e_init));
    chk("enable",   32'(o_enable),  32'(e_en));
    chk("counter",  32'(o_counter), e_en ? 32'(ph - 1) : 32'd0);
    chk("done",     32'(o_done),    32'(e_done));
    chk("val_x",    32'(o_val_x),   32'(m_val));
    chk("result",   o_result,       m_res);
    chk("reminder", o_reminder,     m_rem);
    if (o_done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL done_unexpected: got o_done=1, expected no pending op (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle",   32'(cyc),   32'(e.due));
        chk("done_result",  o_result,   e.res);
        chk("done_reminder", o_reminder, e.rem);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: got o_ready=0, expected 1 within 40 cycles");
    end
  endtask

  task automatic run_op(logic [15:0] v);
    wait_ready();
    i_start = 1'b1;
    i_val_x = v;
    @(negedge clk);
    i_start = 1'b0;
    repeat (11) begin
      i_val_x = 16'($urandom);
      @(negedge clk);
    end
  endtask

  initial begin
    rst     = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_val_x = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Directed values, including both extremes of the radicand.
    run_op(16'd100);
    run_op(16'd99);
    run_op(16'hFFFF);
    run_op(16'd0);

    // Start held high with a changing radicand: back-to-back operations.
    wait_ready();
    i_start = 1'b1;
    repeat (40) begin
      i_val_x = 16'($urandom);
      @(negedge clk);
    end
    i_start = 1'b0;

    // Abort while the counter shows 3; a concurrent start must be ignored.
    wait_ready();
    i_start = 1'b1;
    i_val_x = 16'd200;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_point_counter", 32'(o_counter), 32'd3);
    i_abort = 1'b1;
    i_start = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    i_start = 1'b0;
    repeat (3) @(negedge clk);

    // Abort together with start in IDLE: nothing happens.
    wait_ready();
    i_start = 1'b1;
    i_abort = 1'b1;
    i_val_x = 16'd144;
    @(negedge clk);
    i_start = 1'b0;
    i_abort = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset while the counter shows 5.
    wait_ready();
    i_start = 1'b1;
    i_val_x = 16'd1234;
    @(negedge clk);
    i_start = 1'b0;
    repeat (6) @(negedge clk);
    chk("reset_point_counter", 32'(o_counter), 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("rst_ready",    32'(o_ready),   32'd1);
    chk("rst_busy",     32'(o_busy),    32'd0);
    chk("rst_enable",   32'(o_enable),  32'd0);
    chk("rst_counter",  32'(o_counter), 32'd0);
    chk("rst_val_x",    32'(o_val_x),   32'd0);
    chk("rst_result",   o_result,       32'd0);
    chk("rst_reminder", o_reminder,     32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op(16'd49);

    // Random operations with occasional aborts at random points.
    repeat (25) begin
      wait_ready();
      i_start = 1'b1;
      case ($urandom_range(0, 3))
        0:       i_val_x = 16'hFFFF;
        1:       i_val_x = 16'($urandom_range(0, 3));
        default: i_val_x = 16'($urandom);
      endcase
      @(negedge clk);
      i_start = 1'b0;
      repeat (11) begin
        i_val_x = 16'($urandom);
        i_abort = ($urandom_range(0, 19) == 0);
        i_start = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
      i_abort = 1'b0;
      i_start = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_ready();
    repeat (3) @(negedge clk);
    chk("pending_ops", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
